// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - DDR4 command encodings, request type and default timings
package ddr_pkg;

  typedef enum logic {
    RD_R = 1'b0,
    WR_R = 1'b1
  } req_t;

  // {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14}
  localparam logic [4:0] DES_C = 5'b11111;
  localparam logic [4:0] ACT_C = 5'b00000;
  localparam logic [4:0] PRE_C = 5'b01010;
  localparam logic [4:0] REF_C = 5'b01001;
  localparam logic [4:0] WR_C  = 5'b01100;
  localparam logic [4:0] RD_C  = 5'b01101;

  localparam int T_RCD_DEF  = 16;
  localparam int T_RP_DEF   = 16;
  localparam int T_RAS_DEF  = 39;
  localparam int T_CCD_DEF  = 4;
  localparam int T_REFI_DEF = 6240;
  localparam int T_RFC_DEF  = 280;

  // ACT carries row[16:14] on the RAS/CAS/WE pins since act_n is low
  function automatic logic [4:0] act_cmd(input logic [2:0] row_hi);
    return ACT_C | {2'b00, row_hi};
  endfunction

endpackage

// File: rtl/ddr_bank_tracker.sv
// rtl/ddr_bank_tracker.sv - open-row and tRAS tracking for 16 DDR4 banks
module ddr_bank_tracker
  import ddr_pkg::*;
#(
  parameter int T_RAS = T_RAS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  idx,
  input  logic [16:0] row,
  input  logic        act,
  input  logic        pre,
  input  logic        prea,
  input  logic        ref_s,
  output logic        hit,
  output logic        bank_open,
  output logic        tras_ok,
  output logic        all_tras_ok,
  output logic        any_open
);

  logic        open_q [16];
  logic [16:0] row_q  [16];
  logic [15:0] tras_q [16];

  // Per-bank state: ACT opens and arms tRAS, PRE closes one bank, PREA/REF close all
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        open_q[i] <= 1'b0;
        row_q[i]  <= '0;
        tras_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (tras_q[i] != 16'd0) tras_q[i] <= tras_q[i] - 16'd1;
        if (prea || ref_s) begin
          open_q[i] <= 1'b0;
        end else if (act && idx == 4'(i)) begin
          open_q[i] <= 1'b1;
          row_q[i]  <= row;
          // loaded on the ACT edge, so zero is reached one cycle before ACT+T_RAS
          tras_q[i] <= 16'(T_RAS - 1);
        end else if (pre && idx == 4'(i)) begin
          open_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bank_open = open_q[idx];
  assign hit       = open_q[idx] && (row_q[idx] == row);
  assign tras_ok   = (tras_q[idx] == 16'd0);

  // Aggregate view used by refresh: PREA waits for every open bank's tRAS
  always_comb begin
    all_tras_ok = 1'b1;
    any_open    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (open_q[i]) begin
        any_open = 1'b1;
        if (tras_q[i] != 16'd0) all_tras_ok = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// rtl/ddr_cmd_scheduler.sv - single-request DDR4 command sequencer with refresh
module ddr_cmd_scheduler
  import ddr_pkg::*;
#(
  parameter int T_RCD  = T_RCD_DEF,
  parameter int T_RP   = T_RP_DEF,
  parameter int T_RAS  = T_RAS_DEF,
  parameter int T_CCD  = T_CCD_DEF,
  parameter int T_REFI = T_REFI_DEF,
  parameter int T_RFC  = T_RFC_DEF
) (
  input  logic        CK_t,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_type,
  input  logic [1:0]  req_bg,
  input  logic [1:0]  req_ba,
  input  logic [16:0] req_row,
  input  logic [9:0]  req_col,
  output logic [4:0]  cmd_o,
  output logic [1:0]  bg_o,
  output logic [1:0]  ba_o,
  output logic [13:0] addr_o,
  output logic        dimm_req,
  output logic        rd_rdy,
  output logic        wr_rdy
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PRE      = 4'd1;
  localparam logic [3:0] S_WAIT_RP  = 4'd2;
  localparam logic [3:0] S_ACT      = 4'd3;
  localparam logic [3:0] S_WAIT_RCD = 4'd4;
  localparam logic [3:0] S_CAS      = 4'd5;
  localparam logic [3:0] S_WAIT_CCD = 4'd6;
  localparam logic [3:0] S_PREA     = 4'd7;
  localparam logic [3:0] S_WAIT_RPA = 4'd8;
  localparam logic [3:0] S_REF      = 4'd9;
  localparam logic [3:0] S_WAIT_RFC = 4'd10;

  logic [3:0]  state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic [15:0] refi_q, refi_d;
  logic        ref_pend_q, ref_pend_d;
  logic        req_pend_q, req_pend_d;

  logic        lat_type;
  logic [1:0]  lat_bg, lat_ba;
  logic [16:0] lat_row;
  logic [9:0]  lat_col;

  logic        accept, use_in;
  logic        eff_type;
  logic [1:0]  eff_bg, eff_ba;
  logic [16:0] eff_row;
  logic [9:0]  eff_col;

  logic        do_act, do_pre, do_cas, do_prea, do_ref;
  logic [4:0]  cmd_d;
  logic [1:0]  bg_d, ba_d;
  logic [13:0] addr_d;
  logic        dimm_d, rd_d, wr_d, ready_d;

  logic        trk_hit, trk_open, trk_tras_ok, trk_all_tras_ok, trk_any_open;

  assign accept = req_valid && req_ready;

  // While idle with nothing latched, classify the incoming request directly so
  // its first command can go out on the accept edge; otherwise use the latch.
  assign use_in   = (state_q == S_IDLE) && !req_pend_q;
  assign eff_type = use_in ? req_type : lat_type;
  assign eff_bg   = use_in ? req_bg   : lat_bg;
  assign eff_ba   = use_in ? req_ba   : lat_ba;
  assign eff_row  = use_in ? req_row  : lat_row;
  assign eff_col  = use_in ? req_col  : lat_col;

  ddr_bank_tracker #(.T_RAS(T_RAS)) u_bank_tracker (
    .clk         (CK_t),
    .rst         (reset),
    .idx         ({eff_bg, eff_ba}),
    .row         (eff_row),
    .act         (do_act),
    .pre         (do_pre),
    .prea        (do_prea),
    .ref_s       (do_ref),
    .hit         (trk_hit),
    .bank_open   (trk_open),
    .tras_ok     (trk_tras_ok),
    .all_tras_ok (trk_all_tras_ok),
    .any_open    (trk_any_open)
  );

  // Next state, timing counters and the command to drive on the next cycle
  always_comb begin
    state_d    = state_q;
    wait_d     = (wait_q != 16'd0) ? wait_q - 16'd1 : 16'd0;
    refi_d     = (refi_q == 16'd0) ? 16'(T_REFI) : refi_q - 16'd1;
    ref_pend_d = ref_pend_q | (refi_q == 16'd0);
    req_pend_d = req_pend_q | accept;
    do_act     = 1'b0;
    do_pre     = 1'b0;
    do_cas     = 1'b0;
    do_prea    = 1'b0;
    do_ref     = 1'b0;

    // Wait counters load T-2: one cycle is the command itself, one is the reload edge
    case (state_q)
      S_IDLE: begin
        if (req_pend_q || accept) begin
          if (trk_hit)          do_cas = 1'b1;
          else if (!trk_open)   do_act = 1'b1;
          else if (trk_tras_ok) do_pre = 1'b1;
        end else if (ref_pend_q) begin
          if (!trk_any_open)        do_ref  = 1'b1;
          else if (trk_all_tras_ok) do_prea = 1'b1;
        end
      end
      S_PRE: begin
        state_d = S_WAIT_RP;
        wait_d  = 16'(T_RP - 2);
      end
      S_WAIT_RP:  if (wait_q == 16'd0) do_act = 1'b1;
      S_ACT: begin
        state_d = S_WAIT_RCD;
        wait_d  = 16'(T_RCD - 2);
      end
      S_WAIT_RCD: if (wait_q == 16'd0) do_cas = 1'b1;
      S_CAS: begin
        state_d = S_WAIT_CCD;
        wait_d  = 16'(T_CCD - 2);
      end
      S_WAIT_CCD: if (wait_q == 16'd0) state_d = S_IDLE;
      S_PREA: begin
        state_d = S_WAIT_RPA;
        wait_d  = 16'(T_RP - 2);
      end
      S_WAIT_RPA: if (wait_q == 16'd0) do_ref = 1'b1;
      S_REF: begin
        state_d = S_WAIT_RFC;
        wait_d  = 16'(T_RFC - 2);
      end
      S_WAIT_RFC: if (wait_q == 16'd0) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // bg/ba/addr hold their last value between commands
    cmd_d  = DES_C;
    bg_d   = bg_o;
    ba_d   = ba_o;
    addr_d = addr_o;
    dimm_d = dimm_req;
    rd_d   = 1'b0;
    wr_d   = 1'b0;

    if (do_act) begin
      state_d = S_ACT;
      cmd_d   = act_cmd(eff_row[16:14]);
      bg_d    = eff_bg;
      ba_d    = eff_ba;
      addr_d  = eff_row[13:0];
    end
    if (do_pre) begin
      state_d = S_PRE;
      cmd_d   = PRE_C;
      bg_d    = eff_bg;
      ba_d    = eff_ba;
      addr_d  = 14'h0000;
    end
    if (do_cas) begin
      state_d    = S_CAS;
      cmd_d      = (eff_type == WR_R) ? WR_C : RD_C;
      bg_d       = eff_bg;
      ba_d       = eff_ba;
      addr_d     = {4'b0100, eff_col};
      dimm_d     = eff_type;
      rd_d       = (eff_type == RD_R);
      wr_d       = (eff_type == WR_R);
      req_pend_d = 1'b0;
    end
    if (do_prea) begin
      state_d = S_PREA;
      cmd_d   = PRE_C;
      bg_d    = 2'b00;
      ba_d    = 2'b00;
      addr_d  = 14'h0400;
    end
    if (do_ref) begin
      state_d    = S_REF;
      cmd_d      = REF_C;
      bg_d       = 2'b00;
      ba_d       = 2'b00;
      addr_d     = 14'h0000;
      ref_pend_d = 1'b0;
    end

    ready_d = (state_d == S_IDLE) && !ref_pend_d && !req_pend_d;
  end

  // FSM, counters and the registered pin outputs
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      refi_q     <= 16'(T_REFI);
      ref_pend_q <= 1'b0;
      req_pend_q <= 1'b0;
      cmd_o      <= DES_C;
      bg_o       <= '0;
      ba_o       <= '0;
      addr_o     <= '0;
      dimm_req   <= RD_R;
      rd_rdy     <= 1'b0;
      wr_rdy     <= 1'b0;
      req_ready  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      refi_q     <= refi_d;
      ref_pend_q <= ref_pend_d;
      req_pend_q <= req_pend_d;
      cmd_o      <= cmd_d;
      bg_o       <= bg_d;
      ba_o       <= ba_d;
      addr_o     <= addr_d;
      dimm_req   <= dimm_d;
      rd_rdy     <= rd_d;
      wr_rdy     <= wr_d;
      req_ready  <= ready_d;
    end
  end

  // Request latch, captured on the handshake
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      lat_type <= RD_R;
      lat_bg   <= '0;
      lat_ba   <= '0;
      lat_row  <= '0;
      lat_col  <= '0;
    end else if (accept) begin
      lat_type <= req_type;
      lat_bg   <= req_bg;
      lat_ba   <= req_ba;
      lat_row  <= req_row;
      lat_col  <= req_col;
    end
  end

endmodule
